// File: rtl/dma_bus_slave_mem_if.sv
// dma_bus_slave_mem_if: DMA master bus between a channel controller (master) and a memory responder (slave).
interface dma_bus_slave_mem_if;
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rd_en;
    logic        hready;
    logic        busy;
    logic        err;

    modport master (output wr, rd, addr, wdata, input rdata, rd_en, hready, busy, err);
    modport slave  (input wr, rd, addr, wdata, output rdata, rd_en, hready, busy, err);
endinterface

// File: rtl/dma_bus_slave_mem.sv
// dma_bus_slave_mem: memory-backed DMA bus responder with programmable wait states.
// Optional BUS_SLV_ADDR_ERR_EN flags out-of-range requests with err and suppresses their memory effect.
module dma_bus_slave_mem #(
    parameter int          DEPTH       = 64,
    parameter int          AW          = 6,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input logic               clk,
    input logic               rst,
    dma_bus_slave_mem_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [7:0]  WLOAD = 8'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
    localparam logic [31:0] MASK  = ~32'(DEPTH * 4 - 1);

    state_t        state, state_nx;
    logic [7:0]    wcnt;
    logic [31:0]   addr_q, wdata_q, rdata_q;
    logic          op_wr_q;
    logic [31:0]   mem [DEPTH];
    logic          accept, enter_resp, w_cur, ok;
    logic [31:0]   a_cur, d_cur;
    logic [AW-1:0] idx;
    logic          unused_addr;

    // With zero wait states the response is entered at the accepting edge, so use the live bus fields.
    always_comb begin
        accept     = (state == IDLE) && (bus.wr || bus.rd);
        a_cur      = (state == IDLE) ? bus.addr : addr_q;
        d_cur      = (state == IDLE) ? bus.wdata : wdata_q;
        w_cur      = (state == IDLE) ? bus.wr : op_wr_q;
        idx        = a_cur[AW+1:2];
        state_nx   = (state == IDLE) ? (accept ? (WAIT_CYCLES > 0 ? WAIT : RESP) : IDLE) :
                     (state == WAIT) ? (wcnt == 8'd0 ? RESP : WAIT) : IDLE;
        enter_resp = (state_nx == RESP) && !rst;
    end

`ifdef BUS_SLV_ADDR_ERR_EN
    assign ok          = (a_cur & MASK) == BASE_ADDR;
    assign bus.err     = (state == RESP) && !ok;
    assign unused_addr = ^a_cur[1:0];
`else
    assign ok          = 1'b1;
    assign bus.err     = 1'b0;
    assign unused_addr = ^{a_cur[1:0], a_cur[31:AW+2], MASK};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt    <= 8'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            op_wr_q <= 1'b0;
        end else if (accept) begin
            wcnt    <= WLOAD;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            op_wr_q <= bus.wr;
        end else if (state == WAIT && wcnt != 8'd0) begin
            wcnt <= wcnt - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (enter_resp && w_cur && ok) mem[idx] <= d_cur;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= 32'd0;
        else if (enter_resp && !w_cur) rdata_q <= ok ? mem[idx] : 32'd0;
    end

    assign bus.rdata  = rdata_q;
    assign bus.rd_en  = (state == RESP) && !op_wr_q;
    assign bus.hready = (state == RESP) && op_wr_q;
    assign bus.busy   = state != IDLE;
endmodule

// File: tb/tb_dma_bus_slave_mem.sv
// tb_dma_bus_slave_mem: three responders (2, 3 and 0 wait states) checked against a timeline model every cycle.
module tb_dma_bus_slave_mem;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          WC [3] = '{2, 3, 0};
`ifdef BUS_SLV_ADDR_ERR_EN
    localparam bit EM = 1'b1;
`else
    localparam bit EM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  wr_v = '0, rd_v = '0;
    logic [31:0] addr_v [3] = '{0, 0, 0};
    logic [31:0] wdata_v [3] = '{0, 0, 0};
    logic [2:0]  rd_en_o, hready_o, busy_o, err_o;
    logic [31:0] rdata_o [3];

    dma_bus_slave_mem_if b0 ();
    dma_bus_slave_mem_if b1 ();
    dma_bus_slave_mem_if b2 ();

    assign b0.wr = wr_v[0]; assign b0.rd = rd_v[0]; assign b0.addr = addr_v[0]; assign b0.wdata = wdata_v[0];
    assign b1.wr = wr_v[1]; assign b1.rd = rd_v[1]; assign b1.addr = addr_v[1]; assign b1.wdata = wdata_v[1];
    assign b2.wr = wr_v[2]; assign b2.rd = rd_v[2]; assign b2.addr = addr_v[2]; assign b2.wdata = wdata_v[2];
    assign rd_en_o  = {b2.rd_en, b1.rd_en, b0.rd_en};
    assign hready_o = {b2.hready, b1.hready, b0.hready};
    assign busy_o   = {b2.busy, b1.busy, b0.busy};
    assign err_o    = {b2.err, b1.err, b0.err};
    assign rdata_o[0] = b0.rdata;
    assign rdata_o[1] = b1.rdata;
    assign rdata_o[2] = b2.rdata;

    dma_bus_slave_mem #(.DEPTH(DEPTH), .AW(6), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    dma_bus_slave_mem #(.DEPTH(DEPTH), .AW(6), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    dma_bus_slave_mem #(.DEPTH(DEPTH), .AW(6), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

    // Timeline model: each accepted request occupies cycles acc..resp, response in cycle resp.
    int          cyc = 0;
    bit          pend [3];
    int          acc [3], resp [3];
    bit          op_rd [3], oor [3];
    logic [31:0] rval [3];
    logic [31:0] exp_rdata [3] = '{0, 0, 0};
    logic [31:0] mm [3][DEPTH];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                pend[i] = 1'b0;
                exp_rdata[i] = 32'd0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if ((!pend[i] || cyc >= resp[i] + 2) && (wr_v[i] || rd_v[i])) begin
                    automatic int ix = int'(addr_v[i] / 4) % DEPTH;
                    pend[i]  = 1'b1;
                    acc[i]   = cyc;
                    resp[i]  = cyc + WC[i];
                    op_rd[i] = !wr_v[i];
                    oor[i]   = (addr_v[i] / (DEPTH * 4)) != (BASE / (DEPTH * 4));
                    if (wr_v[i]) begin
                        if (!(EM && oor[i])) mm[i][ix] = wdata_v[i];
                    end else begin
                        rval[i] = (EM && oor[i]) ? 32'd0 : mm[i][ix];
                    end
                end
                if (pend[i] && cyc == resp[i] && op_rd[i]) exp_rdata[i] = rval[i];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            automatic bit act = pend[i] && cyc >= acc[i] && cyc <= resp[i];
            automatic bit rc  = pend[i] && cyc == resp[i];
            chk($sformatf("busy[%0d]@%0d", i, cyc), 32'(busy_o[i]), 32'(act));
            chk($sformatf("rd_en[%0d]@%0d", i, cyc), 32'(rd_en_o[i]), 32'(rc && op_rd[i]));
            chk($sformatf("hready[%0d]@%0d", i, cyc), 32'(hready_o[i]), 32'(rc && !op_rd[i]));
            chk($sformatf("err[%0d]@%0d", i, cyc), 32'(err_o[i]), 32'(rc && EM && oor[i]));
            chk($sformatf("rdata[%0d]@%0d", i, cyc), rdata_o[i], exp_rdata[i]);
        end
    endtask

    task automatic req(input int i, input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        tick();
        wr_v[i] = w; rd_v[i] = r; addr_v[i] = a; wdata_v[i] = d;
        tick();
        wr_v[i] = 1'b0; rd_v[i] = 1'b0;
    endtask

    task automatic watch(input int i, input int n, output int nrd, output int nhr, output int ner, output int nbz);
        nrd = 0; nhr = 0; ner = 0; nbz = 0;
        repeat (n) begin
            tick();
            nrd += int'(rd_en_o[i]); nhr += int'(hready_o[i]);
            ner += int'(err_o[i]); nbz += int'(busy_o[i]);
        end
    endtask

    function automatic logic [31:0] pat(input int k);
        return 32'hA500_0000 ^ (32'(k) * 32'h0001_0203);
    endfunction

    int nrd, nhr, ner, nbz;

    initial begin
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset busy[%0d]", i), 32'(busy_o[i]), 32'd0);
            chk($sformatf("reset rd_en[%0d]", i), 32'(rd_en_o[i]), 32'd0);
            chk($sformatf("reset rdata[%0d]", i), rdata_o[i], 32'd0);
        end
        @(posedge clk); #2 rst = 1'b0;

        // Two wait states: write response two cycles after the accepting edge.
        req(0, 1, 0, BASE + 32'h8, 32'h1234_5678);
        chk("t1 busy at acc", 32'(busy_o[0]), 32'd1);
        chk("t1 hready at acc", 32'(hready_o[0]), 32'd0);
        tick(); chk("t1 hready +1", 32'(hready_o[0]), 32'd0);
        tick(); chk("t1 hready +2", 32'(hready_o[0]), 32'd1);
        tick(); chk("t1 busy after resp", 32'(busy_o[0]), 32'd0);
        req(0, 0, 1, BASE + 32'h8, 32'h0);
        tick(); tick();
        chk("t1 rd_en", 32'(rd_en_o[0]), 32'd1);
        chk("t1 rdata", rdata_o[0], 32'h1234_5678);

        req(0, 1, 1, BASE + 32'h4, 32'hA5A5_0001);
        watch(0, 4, nrd, nhr, ner, nbz);
        chk("t2 rd_en pulses", 32'(nrd), 32'd0);
        chk("t2 hready pulses", 32'(nhr), 32'd1);
        req(0, 0, 1, BASE + 32'h4, 32'h0);
        watch(0, 4, nrd, nhr, ner, nbz);
        chk("t2 readback", rdata_o[0], 32'hA5A5_0001);

        // Second read during WAIT must be dropped.
        req(1, 1, 0, BASE + 32'h10, 32'hCAFE_0010);
        repeat (5) tick();
        req(1, 1, 0, BASE + 32'h14, 32'hBEEF_0014);
        repeat (5) tick();
        req(1, 0, 1, BASE + 32'h10, 32'h0);
        req(1, 0, 1, BASE + 32'h14, 32'h0);
        watch(1, 8, nrd, nhr, ner, nbz);
        chk("t3 rd_en pulses", 32'(nrd), 32'd1);
        chk("t3 rdata", rdata_o[1], 32'hCAFE_0010);

        req(0, 1, 0, BASE, 32'h1111_0000);
        repeat (4) tick();
        req(0, 1, 0, BASE + DEPTH * 4, 32'hFFFF_0000);
        watch(0, 4, nrd, nhr, ner, nbz);
        chk("t4 hready pulses", 32'(nhr), 32'd1);
        chk("t4 err pulses", 32'(ner), EM ? 32'd1 : 32'd0);
        req(0, 0, 1, BASE, 32'h0);
        watch(0, 4, nrd, nhr, ner, nbz);
        chk("t4 word0", rdata_o[0], EM ? 32'h1111_0000 : 32'hFFFF_0000);

        // Reset in the middle of a WAIT: outputs clear at once and the read never completes.
        req(1, 0, 1, BASE + 32'h14, 32'h0);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("t5 busy in rst", 32'(busy_o[1]), 32'd0);
        chk("t5 rd_en in rst", 32'(rd_en_o[1]), 32'd0);
        chk("t5 hready in rst", 32'(hready_o[1]), 32'd0);
        chk("t5 rdata in rst", rdata_o[1], 32'd0);
        @(posedge clk); #2 rst = 1'b0;
        watch(1, 10, nrd, nhr, ner, nbz);
        chk("t5 responses after rst", 32'(nrd + nhr), 32'd0);
        chk("t5 busy after rst", 32'(nbz), 32'd0);

        // Zero wait states, a request every two cycles across all words.
        for (int k = 0; k < DEPTH; k++) begin
            req(2, 1, 0, BASE + 32'(4 * k), pat(k));
            chk($sformatf("t6 hready w%0d", k), 32'(hready_o[2]), 32'd1);
        end
        for (int k = 0; k < DEPTH; k++) begin
            req(2, 0, 1, BASE + 32'(4 * k), 32'h0);
            chk($sformatf("t6 rd_en w%0d", k), 32'(rd_en_o[2]), 32'd1);
            chk($sformatf("t6 rdata w%0d", k), rdata_o[2], pat(k));
        end
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
